cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have control inputs, each 1 bit, driven by the sequencer: membus, arload, pcload, pcinc, pcbus, drload, drbus, alusel, acload, acinc, irload.
REQ-004 SHALL have port op, output, 2 bits: current IR contents, returned to the sequencer.
REQ-005 SHALL have program-load port mem_we, input, 1 bit: write enable for the program memory.
REQ-006 SHALL have program-load port mem_waddr, input, 6 bits: write address.
REQ-007 SHALL have program-load port mem_wdata, input, 8 bits: write data.
REQ-008 SHALL have debug outputs ac_out (8 bits), pc_out (6 bits) and bus_err (1 bit).

Function
REQ-009 SHALL hold these registers: AR 6b, PC 6b, DR 8b, AC 8b, IR 2b, bus_err 1b.
REQ-010 SHALL hold memory as 64x8, read combinationally at address AR.
REQ-011 SHALL use instruction format IR[7:6]=opcode, [5:0]=address; ADD=00, AND=01, JMP=10, INC=11.
REQ-012 SHALL drive the internal 8-bit bus as follows:
- membus -> mem[AR];
- else drbus -> DR;
- else pcbus -> {2'b00, PC};
- else 8'h00.
REQ-013 SHALL set bus_err on any cycle with two or more of membus/drbus/pcbus high; it is sticky until rst. The bus still follows the priority in REQ-012.
REQ-014 SHALL make every register load capture the bus value of the same cycle. All loads happen on one edge, so simultaneous source and destination (e.g. drload with drbus) read the pre-edge value.
REQ-015 SHALL load the registers as follows:
- arload: AR <= bus[5:0];
- drload: DR <= bus;
- irload: IR <= bus[7:6].
REQ-016 SHALL update PC as follows:
- pcload: PC <= bus[5:0];
- else pcinc: PC <= PC+1, modulo 64 (63 -> 0);
- pcload wins over pcinc.
REQ-017 SHALL update AC as follows:
- acload with alusel=0: AC <= (AC+DR) mod 256, carry discarded;
- acload with alusel=1: AC <= AC & DR;
- else acinc: AC <= AC+1 mod 256;
- acload wins over acinc.
REQ-018 SHALL, when mem_we=1, write mem[mem_waddr] <= mem_wdata at the edge. A same-cycle read of that address returns the old data. Writes are allowed at any time, including during rst.
REQ-019 SHALL drive op=IR, ac_out=AC and pc_out=PC directly from the registers, with no combinational path from the control inputs.
REQ-020 SHALL hold every register whose load/inc control is low.
REQ-021 SHALL place no ordering requirements on the control inputs. Any combination of control inputs SHALL be accepted, with conflicts resolved per REQ-012/016/017.

Reset
REQ-022 SHALL, on rst=1 at an edge, set AR=0, PC=0, DR=0, AC=0, IR=0 and bus_err=0, overriding all control inputs in that cycle.
REQ-023 SHALL leave memory contents unaffected by rst.
REQ-024 SHALL abandon an instruction interrupted by rst mid-sequence; the next sequence starts from PC=0.

Verification
REQ-025 SHALL cover reset: load registers with nonzero values, assert rst for 1 cycle -> op=0, ac_out=0, pc_out=0, bus_err=0; memory contents unchanged.
REQ-026 SHALL cover ADD: mem[0]=8'h05, mem[5]=8'h03, AC=0. Drive FETCH1..3 then ADD1 (membus+drload), ADD2 (drbus+acload, alusel=0) -> op=00 after FETCH3, ac_out=8'h03, pc_out=1.
REQ-027 SHALL cover AND and ADD overflow:
- AC=8'hF0, mem[1]=8'h46, mem[6]=8'h3C -> AC=8'h30;
- ADD with AC=8'hFF, DR=8'h02 -> AC=8'h01.
REQ-028 SHALL cover JMP: mem[PC]=8'hA0, drive fetch then JMP1 (drbus+pcload) -> op=10, pc_out=6'h20.
REQ-029 SHALL cover wrap and priority:
- INC with AC=8'hFF -> 8'h00;
- pcinc at PC=63 -> 0;
- pcload and pcinc together with bus=8'h15 -> PC=6'h15.
REQ-030 SHALL cover bus conflict: membus and drbus together with mem[AR]=8'h11, DR=8'h22, drload -> DR=8'h11, bus_err=1; bus_err stays 1 until rst.

Source files
------------

// File: rtl/cpu_datapath_if.sv
// Sequencer-to-datapath control bundle: one-bit micro-operation strobes out,
// current opcode back.
interface cpu_datapath_if;
  logic       membus;
  logic       arload;
  logic       pcload;
  logic       pcinc;
  logic       pcbus;
  logic       drload;
  logic       drbus;
  logic       alusel;
  logic       acload;
  logic       acinc;
  logic       irload;
  logic [1:0] op;

  modport master (
    output membus, arload, pcload, pcinc, pcbus,
    output drload, drbus, alusel, acload, acinc, irload,
    input  op
  );

  modport slave (
    input  membus, arload, pcload, pcinc, pcbus,
    input  drload, drbus, alusel, acload, acinc, irload,
    output op
  );
endinterface

// File: rtl/cpu_datapath.sv
// Accumulator-machine datapath: AR/PC/DR/AC/IR around a single 8-bit bus,
// 64x8 program memory with a separate load port, sticky bus-conflict flag.
module cpu_datapath (
  input  logic                 clk,
  input  logic                 rst,
  cpu_datapath_if.slave        ctl,
  input  logic                 mem_we,
  input  logic [5:0]           mem_waddr,
  input  logic [7:0]           mem_wdata,
  output logic [7:0]           ac_out,
  output logic [5:0]           pc_out,
  output logic                 bus_err
);

  logic [5:0] ar;
  logic [5:0] pc;
  logic [7:0] dr;
  logic [7:0] ac;
  logic [1:0] ir;
  logic       err;

  logic [7:0] mem [64];
  logic [7:0] mem_rdata;
  logic [7:0] bus;
  logic [1:0] n_src;
  logic       conflict;
  logic [7:0] alu_res;

  // Memory is deliberately outside the reset domain so a program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign mem_rdata = mem[ar];

  always_comb begin
    bus = '0;
    if (ctl.membus)
      bus = mem_rdata;
    else if (ctl.drbus)
      bus = dr;
    else if (ctl.pcbus)
      bus = {2'b00, pc};
  end

  assign n_src    = {1'b0, ctl.membus} + {1'b0, ctl.drbus} + {1'b0, ctl.pcbus};
  assign conflict = (n_src >= 2'd2);

  always_comb begin
    alu_res = ac + dr;
    if (ctl.alusel)
      alu_res = ac & dr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar  <= '0;
      pc  <= '0;
      dr  <= '0;
      ac  <= '0;
      ir  <= '0;
      err <= 1'b0;
    end else begin
      if (ctl.arload)
        ar <= bus[5:0];
      if (ctl.drload)
        dr <= bus;
      if (ctl.irload)
        ir <= bus[7:6];

      if (ctl.pcload)
        pc <= bus[5:0];
      else if (ctl.pcinc)
        pc <= pc + 6'd1;

      if (ctl.acload)
        ac <= alu_res;
      else if (ctl.acinc)
        ac <= ac + 8'd1;

      if (conflict)
        err <= 1'b1;
    end
  end

  assign ctl.op  = ir;
  assign ac_out  = ac;
  assign pc_out  = pc;
  assign bus_err = err;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed micro-op sequences plus random control
// vectors, checked by a scoreboard against an arithmetic reference model.
module tb_cpu_datapath;

  localparam logic [10:0] C_MEMBUS = 11'h400;
  localparam logic [10:0] C_ARLOAD = 11'h200;
  localparam logic [10:0] C_PCLOAD = 11'h100;
  localparam logic [10:0] C_PCINC  = 11'h080;
  localparam logic [10:0] C_PCBUS  = 11'h040;
  localparam logic [10:0] C_DRLOAD = 11'h020;
  localparam logic [10:0] C_DRBUS  = 11'h010;
  localparam logic [10:0] C_ALUSEL = 11'h008;
  localparam logic [10:0] C_ACLOAD = 11'h004;
  localparam logic [10:0] C_ACINC  = 11'h002;
  localparam logic [10:0] C_IRLOAD = 11'h001;

  localparam logic [10:0] FETCH1 = C_PCBUS  | C_ARLOAD;
  localparam logic [10:0] FETCH2 = C_MEMBUS | C_DRLOAD | C_PCINC;
  localparam logic [10:0] FETCH3 = C_DRBUS  | C_IRLOAD | C_ARLOAD;
  localparam logic [10:0] EXE1   = C_MEMBUS | C_DRLOAD;
  localparam logic [10:0] ADD2   = C_DRBUS  | C_ACLOAD;
  localparam logic [10:0] AND2   = C_DRBUS  | C_ACLOAD | C_ALUSEL;
  localparam logic [10:0] JMP1   = C_DRBUS  | C_PCLOAD;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_we;
  logic [5:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] ac_out;
  logic [5:0] pc_out;
  logic       bus_err;

  cpu_datapath_if ctl ();

  cpu_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .ctl       (ctl),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .ac_out    (ac_out),
    .pc_out    (pc_out),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ac;
    int pc;
    int op;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Reference model state, held as plain integers.
  int m_ar, m_pc, m_dr, m_ac, m_ir, m_err;
  int m_mem [64];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic [10:0] c, input logic r,
                      input logic we, input logic [5:0] wa, input logic [7:0] wd);
    int   bus, nsrc;
    bit   mb, db, pb;
    exp_t e;
    {ctl.membus, ctl.arload, ctl.pcload, ctl.pcinc, ctl.pcbus, ctl.drload,
     ctl.drbus, ctl.alusel, ctl.acload, ctl.acinc, ctl.irload} = c;
    rst = r; mem_we = we; mem_waddr = wa; mem_wdata = wd;

    mb = c[10]; pb = c[6]; db = c[4];
    if (mb)      bus = m_mem[m_ar];
    else if (db) bus = m_dr;
    else if (pb) bus = m_pc;
    else         bus = 0;
    nsrc = int'(mb) + int'(db) + int'(pb);

    if (r) begin
      m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_err = 0;
    end else begin
      int old_ac, old_dr, old_pc;
      old_ac = m_ac; old_dr = m_dr; old_pc = m_pc;
      if (c[9]) m_ar = bus % 64;
      if (c[5]) m_dr = bus;
      if (c[0]) m_ir = bus / 64;
      if (c[8])      m_pc = bus % 64;
      else if (c[7]) m_pc = (old_pc + 1) % 64;
      if (c[2])      m_ac = c[3] ? (old_ac & old_dr) : (old_ac + old_dr) % 256;
      else if (c[1]) m_ac = (old_ac + 1) % 256;
      if (nsrc >= 2) m_err = 1;
    end
    if (we) m_mem[wa] = wd;

    e.ac = m_ac; e.pc = m_pc; e.op = m_ir; e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ops(input logic [10:0] c);
    step(c, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic do_reset();
    step(11'd0, 1'b1, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    step(11'd0, 1'b0, 1'b1, a, d);
  endtask

  task automatic fetch();
    ops(FETCH1); ops(FETCH2); ops(FETCH3);
  endtask

  // Monitor: one expected entry per clock, compared 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_ac",  int'(ac_out),        e.ac);
        chk("sb_pc",  int'(pc_out),        e.pc);
        chk("sb_op",  int'(ctl.op),        e.op);
        chk("sb_err", int'(bus_err),       e.err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rc;
    rst = 1'b1; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    {ctl.membus, ctl.arload, ctl.pcload, ctl.pcinc, ctl.pcbus, ctl.drload,
     ctl.drbus, ctl.alusel, ctl.acload, ctl.acinc, ctl.irload} = '0;
    m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_err = 0;
    @(negedge clk);

    // Fill memory while held in reset.
    for (int i = 0; i < 64; i++)
      step(11'd0, 1'b1, 1'b1, 6'(i), 8'(i * 7 + 3));

    // ADD: mem[0]=05, mem[5]=03.
    wr(6'd0, 8'h05); wr(6'd5, 8'h03);
    fetch();
    chk("add_op", int'(ctl.op), 0);
    ops(EXE1); ops(ADD2);
    chk("add_ac", int'(ac_out), 8'h03);
    chk("add_pc", int'(pc_out), 1);

    // Reset with nonzero state and active controls; memory survives.
    ops(C_PCBUS | C_ACINC | C_IRLOAD | C_PCINC);
    step(11'h7FF, 1'b1, 1'b0, 6'd0, 8'd0);
    chk("rst_ac",  int'(ac_out), 0);
    chk("rst_pc",  int'(pc_out), 0);
    chk("rst_op",  int'(ctl.op), 0);
    chk("rst_err", int'(bus_err), 0);
    ops(EXE1); ops(ADD2);
    chk("rst_mem_kept", int'(ac_out), 8'h05);

    // AND: AC=F0 via ADD, then AND with 3C.
    do_reset();
    wr(6'd0, 8'h07); wr(6'd7, 8'hF0); wr(6'd1, 8'h46); wr(6'd6, 8'h3C);
    fetch(); ops(EXE1); ops(ADD2);
    chk("and_pre_ac", int'(ac_out), 8'hF0);
    fetch();
    chk("and_op", int'(ctl.op), 1);
    ops(EXE1); ops(AND2);
    chk("and_ac", int'(ac_out), 8'h30);

    // ADD overflow FF + 02 -> 01, then JMP to 0x20.
    do_reset();
    wr(6'd0, 8'h08); wr(6'd8, 8'hFF); wr(6'd1, 8'h09); wr(6'd9, 8'h02);
    wr(6'd2, 8'hA0);
    fetch(); ops(EXE1); ops(ADD2);
    fetch(); ops(EXE1); ops(ADD2);
    chk("add_ovf_ac", int'(ac_out), 8'h01);
    fetch();
    chk("jmp_op", int'(ctl.op), 2);
    ops(JMP1);
    chk("jmp_pc", int'(pc_out), 6'h20);

    // INC wrap FF -> 00.
    do_reset();
    fetch(); ops(EXE1); ops(ADD2);
    ops(C_ACINC);
    chk("inc_wrap_ac", int'(ac_out), 0);

    // PC wrap 63 -> 0 after JMP to 0x3F.
    do_reset();
    wr(6'd0, 8'hBF);
    fetch(); ops(JMP1);
    chk("jmp63_pc", int'(pc_out), 63);
    ops(C_PCINC);
    chk("pc_wrap", int'(pc_out), 0);

    // pcload beats pcinc with bus = 15.
    do_reset();
    wr(6'd0, 8'h15);
    ops(EXE1);
    ops(C_DRBUS | C_PCLOAD | C_PCINC);
    chk("pc_prio", int'(pc_out), 6'h15);

    // Bus conflict: membus wins over drbus, error is sticky until rst.
    do_reset();
    wr(6'd0, 8'h22);
    ops(EXE1);
    wr(6'd0, 8'h11);
    ops(C_MEMBUS | C_DRBUS | C_DRLOAD);
    chk("conf_err", int'(bus_err), 1);
    ops(JMP1);
    chk("conf_dr", int'(pc_out), 6'h11);
    ops(C_PCINC); ops(C_ACINC);
    chk("conf_sticky", int'(bus_err), 1);
    do_reset();
    chk("conf_clr", int'(bus_err), 0);

    // Random control vectors; bus sources usually one-hot, sometimes colliding.
    for (int n = 0; n < 600; n++) begin
      rc = 11'($urandom) & ~(C_MEMBUS | C_DRBUS | C_PCBUS);
      case ($urandom_range(0, 9))
        0, 1, 2: rc |= C_MEMBUS;
        3, 4:    rc |= C_DRBUS;
        5, 6:    rc |= C_PCBUS;
        7:       rc |= 11'($urandom) & (C_MEMBUS | C_DRBUS | C_PCBUS);
        default: ;
      endcase
      step(rc, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           6'($urandom), 8'($urandom));
    end

    @(posedge clk); #3;
    chk("sb_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
